count_seq_monitor: RTL
======================

// Module: count_seq_monitor
// PURPOSE
//  Downstream checker for a free-running binary counter stage (e.g. 4-bit count-up).
//  Samples the counter value each valid cycle and checks it advances by exactly +1 mod 2^WIDTH.
//  Locks after a run of good steps. Once locked, reports sequence errors and wrap events.
//  Keeps saturating error and wrapping wrap statistics for debug/status readout.
// PARAMETERS
//  WIDTH      4  width of monitored count value
//  LOCK_CNT   3  consecutive good steps required to enter LOCKED (>=1)
//  ERR_CNT_W  8  width of error counter (saturating)
//  WRAP_CNT_W 8  width of wrap counter (wraps modulo 2^WRAP_CNT_W)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous active-high reset
//  cnt_in      in   WIDTH       monitored counter value
//  cnt_vld     in   1           cnt_in valid this cycle
//  clr         in   1           synchronous clear of statistics
//  locked      out  1           monitor is in LOCKED state
//  err_pulse   out  1           1-cycle pulse: step mismatch while LOCKED
//  wrap_pulse  out  1           1-cycle pulse: good step max->0 while LOCKED
//  err_cnt     out  ERR_CNT_W   errors since rst/clr, saturates at all-ones
//  wrap_cnt    out  WRAP_CNT_W  wraps since rst/clr, wraps to 0
//  err_sticky  out  1           only with MON_STICKY_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Reset values: locked=0, err_pulse=0, wrap_pulse=0,
//    err_cnt=0, wrap_cnt=0, err_sticky=0. FSM is SEARCH. Reference sample is empty.
//    Good-run counter is 0.
//  - rst has priority over everything. Asserted mid-operation, everything returns to
//    reset values on that edge.
//  - Only cycles with cnt_vld=1 are evaluated. With cnt_vld=0, all state holds and pulses are 0.
//    Gaps of any length are legal and are not errors.
//  - First valid sample after rst has no reference. It is only captured: no compare, no pulses.
//  - Every later valid sample is a step. It is good iff cnt_in == prev + 1, truncated to WIDTH
//    (all-ones -> 0 is good). prev is then updated to cnt_in, good or bad.
//  - FSM SEARCH: a good step increments the run counter. A bad step zeroes it, with no error reported.
//    The run counter reaching LOCK_CNT moves the FSM to LOCKED and sets locked=1
//    on the edge that captures that step.
//  - FSM LOCKED:
//    - Good step prev=all-ones, cnt_in=0 -> wrap_pulse=1 and wrap_cnt+1.
//    - Bad step -> err_pulse=1, err_cnt+1 (saturating), locked=0, FSM to SEARCH with run=0.
//  - Latency: a sample on edge N produces pulses/counts/locked visible after edge N+1 (1 cycle).
//  - clr (when not in reset) zeroes err_cnt, wrap_cnt and err_sticky. It does not affect
//    the FSM, prev or locked.
//  - clr in the same cycle as an error/wrap event: the counters end at 0 (clr wins).
//    err_pulse/wrap_pulse still assert. err_sticky ends at 0.
//  - err_pulse and wrap_pulse are mutually exclusive.
// CONFIGURATION
//  MON_STICKY_ERR_EN defined:
//    - port err_sticky exists.
//    - It is set by any LOCKED-state error and stays 1 until rst or clr.
//  MON_STICKY_ERR_EN undefined:
//    - port err_sticky and its register are absent.
//    - All other behaviour is identical.
// TESTING (defaults unless noted)
//  1. rst, then cnt_vld=1 with 0,1,...,15,0,1,2 -> locked=1 one cycle after sample 3.
//     wrap_pulse exactly once, one cycle after the second 0. wrap_cnt=1, err_cnt=0.
//  2. Locked stream ..4,5,7,8,9,10 -> err_pulse one cycle after 7, err_cnt=1, locked=0.
//     Relock one cycle after 10.
//  3. Locked, 3, then cnt_vld=0 for 5 cycles, then 4,5 -> no err_pulse, locked stays 1,
//     counts unchanged.
//  4. ERR_CNT_W=2: five relock+error cycles -> err_cnt goes 1,2,3,3,3.
//     err_pulse fires all five times.
//  5. clr asserted on the cycle an error sample is taken -> err_pulse=1, err_cnt=0, and
//     err_sticky=0 (MON_STICKY_ERR_EN). Without clr, err_sticky holds 1 indefinitely.
//  6. rst pulse while LOCKED -> all outputs 0 next cycle.
//     Next valid sample is capture-only, no err_pulse even if the value is discontinuous.

Source files
------------

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks a counter stream advances by +1 mod 2^WIDTH, locks, reports errors/wraps
// Optional feature macro: MON_STICKY_ERR_EN (adds err_sticky output)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cnt_in     monitored counter value
//   cnt_vld    cnt_in valid this cycle
//   clr        synchronous clear of err_cnt, wrap_cnt, err_sticky
//   locked     monitor is in LOCKED state
//   err_pulse  one-cycle pulse on a step mismatch while LOCKED
//   wrap_pulse one-cycle pulse on a good max->0 step while LOCKED
//   err_cnt    saturating error count since rst/clr
//   wrap_cnt   wrapping wrap count since rst/clr
//   err_sticky set by any LOCKED error, held until rst/clr (MON_STICKY_ERR_EN only)
module count_seq_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic                  cnt_vld,
    input  logic                  clr,
    output logic                  locked,
    output logic                  err_pulse,
    output logic                  wrap_pulse,
    output logic [ERR_CNT_W-1:0]  err_cnt,
`ifdef MON_STICKY_ERR_EN
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic                  err_sticky
`else
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state;
    logic             have_ref;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] run;
    logic             good;
    logic             sticky;

    assign good   = cnt_in == prev + WIDTH'(1);
    assign locked = state == LOCKED;
`ifdef MON_STICKY_ERR_EN
    assign err_sticky = sticky;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            have_ref   <= 1'b0;
            prev       <= '0;
            run        <= '0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            sticky     <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (cnt_vld) begin
                have_ref <= 1'b1;
                prev     <= cnt_in;
                if (have_ref && state == SEARCH) begin
                    run <= good ? run + RUN_W'(1) : '0;
                    if (good && run == RUN_W'(LOCK_CNT - 1)) begin
                        state <= LOCKED;
                        run   <= '0;
                    end
                end else if (have_ref && good && &prev) begin
                    wrap_pulse <= 1'b1;
                    wrap_cnt   <= wrap_cnt + WRAP_CNT_W'(1);
                end else if (have_ref && !good) begin
                    err_pulse <= 1'b1;
                    err_cnt   <= &err_cnt ? err_cnt : err_cnt + ERR_CNT_W'(1);
                    state     <= SEARCH;
                    run       <= '0;
                    sticky    <= 1'b1;
                end
            end
            // clr overrides any count/sticky update from an event this cycle
            if (clr) begin
                err_cnt  <= '0;
                wrap_cnt <= '0;
                sticky   <= 1'b0;
            end
        end
    end
endmodule
